block_dispatcher: RTL and testbench



---
 rtl/block_dispatcher.sv | 138 +++++++++++++
 tb/tb_block_dispatcher.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/block_dispatcher.sv
// Splits a launch into fixed-size blocks and sequences each compute core through
// reset/start/done, raising a sticky done once every block has completed.
//   state  | meaning
//   S_IDLE | waiting for start; thread_count sampled here
//   S_RUN  | dispatching blocks to idle cores and retiring completions
//   S_DONE | every block finished, all cores held in reset, done held high
module block_dispatcher #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int TW                = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                thread_count,
    input  logic [NUM_CORES-1:0]      core_done,
    output logic [NUM_CORES-1:0]      core_start,
    output logic [NUM_CORES-1:0]      core_reset,
    output logic [8*NUM_CORES-1:0]    core_block_id,
    output logic [TW*NUM_CORES-1:0]   core_thread_count,
    output logic                      done
);

    localparam int LOG2 = $clog2(THREADS_PER_BLOCK);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                     state_q, state_d;
    logic                           done_q, done_d;
    logic [NUM_CORES-1:0]           start_q, start_d;
    logic [NUM_CORES-1:0]           creset_q, creset_d;
    logic [NUM_CORES-1:0][7:0]      id_q, id_d;
    logic [NUM_CORES-1:0][TW-1:0]   cnt_q, cnt_d;
    logic [8:0]                     total_q, total_d;
    logic [8:0]                     disp_q, disp_d;
    logic [8:0]                     fin_q, fin_d;
    logic [TW-1:0]                  tail_q, tail_d;

    logic [8:0]                     launch_blocks;
    logic [TW-1:0]                  launch_tail;

    // Nine bits so thread_count=255 rounds up without wrapping.
    assign launch_blocks = ({1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1)) >> LOG2;
    assign launch_tail   = (thread_count[LOG2-1:0] == '0) ? TW'(THREADS_PER_BLOCK)
                                                          : TW'(thread_count[LOG2-1:0]);

    always_comb begin
        state_d  = state_q;
        done_d   = done_q;
        start_d  = start_q;
        creset_d = creset_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        total_d  = total_q;
        disp_d   = disp_q;
        fin_d    = fin_q;
        tail_d   = tail_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    total_d = launch_blocks;
                    tail_d  = launch_tail;
                    disp_d  = '0;
                    fin_d   = '0;
                    if (thread_count == 8'd0) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Dispatch keys off the registered reset, so a core retiring this
                // edge sits in reset for at least one full cycle.
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (start_q[i] && core_done[i]) begin
                        start_d[i]  = 1'b0;
                        creset_d[i] = 1'b1;
                        fin_d       = fin_d + 9'd1;
                    end else if (creset_q[i] && (disp_d < total_q)) begin
                        creset_d[i] = 1'b0;
                        start_d[i]  = 1'b1;
                        id_d[i]     = disp_d[7:0];
                        cnt_d[i]    = (disp_d == total_q - 9'd1) ? tail_q
                                                                 : TW'(THREADS_PER_BLOCK);
                        disp_d      = disp_d + 9'd1;
                    end
                end
                if (fin_d == total_q) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            done_q   <= 1'b0;
            start_q  <= '0;
            creset_q <= '1;
            id_q     <= '0;
            cnt_q    <= '0;
            total_q  <= '0;
            disp_q   <= '0;
            fin_q    <= '0;
            tail_q   <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            start_q  <= start_d;
            creset_q <= creset_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            total_q  <= total_d;
            disp_q   <= disp_d;
            fin_q    <= fin_d;
            tail_q   <= tail_d;
        end
    end

    assign core_start        = start_q;
    assign core_reset        = creset_q;
    assign core_block_id     = id_q;
    assign core_thread_count = cnt_q;
    assign done              = done_q;

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher: a launch-level model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_block_dispatcher;

    localparam int NC  = 2;
    localparam int TPB = 4;
    localparam int TW  = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        thread_count = 8'd0;
    logic [NC-1:0]     core_done = '0;
    logic [NC-1:0]     core_start;
    logic [NC-1:0]     core_reset;
    logic [8*NC-1:0]   core_block_id;
    logic [TW*NC-1:0]  core_thread_count;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;

    block_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .thread_count      (thread_count),
        .core_done         (core_done),
        .core_start        (core_start),
        .core_reset        (core_reset),
        .core_block_id     (core_block_id),
        .core_thread_count (core_thread_count),
        .done              (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Launch-level model: blocks handed out in order, per-block thread count from
    // the remaining thread total, done once completed blocks equal the block total.
    int        m_phase = 0;   // 0 waiting, 1 running, 2 finished
    bit        m_valid = 0;
    bit        m_done;
    bit [NC-1:0] m_busy, m_idle;
    int        m_id [NC];
    int        m_cnt [NC];
    int        m_total, m_next, m_fin, m_tc;

    always @(posedge clk) begin
        bit [NC-1:0] was_idle;
        if (reset) begin
            m_valid = 1; m_phase = 0; m_done = 0; m_busy = '0; m_idle = '1;
            for (int i = 0; i < NC; i++) begin m_id[i] = 0; m_cnt[i] = 0; end
            m_total = 0; m_next = 0; m_fin = 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_tc    = int'(thread_count);
                m_total = (m_tc + TPB - 1) / TPB;
                m_next  = 0;
                m_fin   = 0;
                if (m_tc == 0) begin m_done = 1; m_phase = 2; end
                else m_phase = 1;
            end
        end else if (m_phase == 1) begin
            was_idle = m_idle;
            for (int i = 0; i < NC; i++) begin
                if (m_busy[i] && core_done[i]) begin
                    m_busy[i] = 0; m_idle[i] = 1; m_fin++;
                end else if (was_idle[i] && m_next < m_total) begin
                    m_busy[i] = 1; m_idle[i] = 0;
                    m_id[i]   = m_next;
                    m_cnt[i]  = m_tc - m_next * TPB;
                    if (m_cnt[i] > TPB) m_cnt[i] = TPB;
                    m_next++;
                end
            end
            if (m_fin == m_total) begin m_done = 1; m_phase = 2; end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_done",   {31'd0, done}, {31'd0, m_done});
            check("model_start",  {30'd0, core_start}, {30'd0, m_busy});
            check("model_reset",  {30'd0, core_reset}, {30'd0, m_idle});
            for (int i = 0; i < NC; i++) begin
                check("model_id",  {24'd0, core_block_id[8*i +: 8]}, m_id[i] & 32'hff);
                check("model_cnt", {29'd0, core_thread_count[TW*i +: TW]}, m_cnt[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; core_done = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic launch(input int tc);
        start = 1'b1; thread_count = 8'(tc);
        tick();
        start = 1'b0;
    endtask

    initial begin
        int          turn;
        int          starts;
        int          last_cnt;
        bit [NC-1:0] prev_start;

        tick(); tick();
        reset = 1'b0;
        do_reset();
        check("rst_reset", {30'd0, core_reset}, 32'h3);
        check("rst_start", {30'd0, core_start}, 32'h0);
        check("rst_done",  {31'd0, done}, 32'h0);
        check("rst_ids",   {16'd0, core_block_id}, 32'h0);
        check("rst_cnts",  {26'd0, core_thread_count}, 32'h0);

        // 8 threads: two full blocks, finished together
        launch(8);
        check("t8_e0_start", {30'd0, core_start}, 32'h0);
        tick();
        check("t8_e1_start", {30'd0, core_start}, 32'h3);
        check("t8_e1_ids",   {16'd0, core_block_id}, 32'h0100);
        check("t8_e1_cnts",  {26'd0, core_thread_count}, 32'o44);
        core_done = 2'b11;
        tick();
        core_done = 2'b00;
        check("t8_fin_reset", {30'd0, core_reset}, 32'h3);
        check("t8_fin_done",  {31'd0, done}, 32'h1);
        tick(); tick();
        check("t8_sticky", {31'd0, done}, 32'h1);

        // 10 threads: core 1 recycled for the 2-thread tail, start during RUN ignored
        do_reset();
        launch(10);
        tick();
        check("t10_ids",  {16'd0, core_block_id}, 32'h0100);
        check("t10_cnts", {26'd0, core_thread_count}, 32'o44);
        core_done = 2'b10; start = 1'b1; thread_count = 8'd200;
        tick();
        core_done = 2'b00; start = 1'b0; thread_count = 8'd0;
        check("t10_n_reset", {30'd0, core_reset}, 32'h2);
        check("t10_n_start", {30'd0, core_start}, 32'h1);
        tick();
        check("t10_n1_start", {30'd0, core_start}, 32'h3);
        check("t10_n1_id1",   {24'd0, core_block_id[15:8]}, 32'd2);
        check("t10_n1_cnt1",  {29'd0, core_thread_count[5:3]}, 32'd2);
        check("t10_n1_id0",   {24'd0, core_block_id[7:0]}, 32'd0);
        check("t10_n1_done",  {31'd0, done}, 32'h0);
        core_done = 2'b01;
        tick();
        core_done = 2'b00;
        check("t10_partial_done", {31'd0, done}, 32'h0);
        core_done = 2'b10;
        tick();
        core_done = 2'b00;
        check("t10_done", {31'd0, done}, 32'h1);

        // zero-thread launch
        do_reset();
        launch(0);
        check("t0_done",  {31'd0, done}, 32'h1);
        check("t0_start", {30'd0, core_start}, 32'h0);
        tick(); tick();
        check("t0_reset", {30'd0, core_reset}, 32'h3);
        check("t0_start_later", {30'd0, core_start}, 32'h0);

        // single thread, spurious done from idle core 1
        do_reset();
        launch(1);
        tick();
        check("t1_start", {30'd0, core_start}, 32'h1);
        check("t1_cnt0",  {29'd0, core_thread_count[2:0]}, 32'd1);
        check("t1_reset", {30'd0, core_reset}, 32'h2);
        core_done = 2'b10;
        tick();
        core_done = 2'b00;
        check("t1_spurious_done", {31'd0, done}, 32'h0);
        check("t1_spurious_start", {30'd0, core_start}, 32'h1);
        core_done = 2'b01;
        tick();
        core_done = 2'b00;
        check("t1_done", {31'd0, done}, 32'h1);

        // 255 threads: 64 blocks, cores retired in alternating order
        do_reset();
        launch(255);
        turn = 0; starts = 0; last_cnt = -1; prev_start = '0;
        for (int c = 0; c < 2000 && !done; c++) begin
            for (int i = 0; i < NC; i++) begin
                if (core_start[i] && !prev_start[i]) begin
                    starts++;
                    if (core_block_id[8*i +: 8] == 8'd63) last_cnt = int'(core_thread_count[TW*i +: TW]);
                end
            end
            prev_start = core_start;
            if (core_start == 2'b11) begin
                core_done = (turn != 0) ? 2'b10 : 2'b01;
                turn = 1 - turn;
            end else begin
                core_done = core_start;
            end
            tick();
        end
        core_done = 2'b00;
        check("t255_done",    {31'd0, done}, 32'h1);
        check("t255_starts",  starts, 32'd64);
        check("t255_lastcnt", last_cnt, 32'd3);
        tick(); tick(); tick();
        check("t255_sticky", {31'd0, done}, 32'h1);

        // reset mid-run, then a clean 4-thread launch
        do_reset();
        launch(8);
        tick();
        check("mid_started", {30'd0, core_start}, 32'h3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_reset", {30'd0, core_reset}, 32'h3);
        check("mid_rst_start", {30'd0, core_start}, 32'h0);
        check("mid_rst_ids",   {16'd0, core_block_id}, 32'h0);
        launch(4);
        tick();
        check("fresh_start", {30'd0, core_start}, 32'h1);
        check("fresh_id0",   {24'd0, core_block_id[7:0]}, 32'd0);
        check("fresh_cnt0",  {29'd0, core_thread_count[2:0]}, 32'd4);
        core_done = 2'b01;
        tick();
        core_done = 2'b00;
        check("fresh_done", {31'd0, done}, 32'h1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
